output_stream: RTL and testbench
================================

// Module: output_stream
// PURPOSE
//  Downstream stage of alpha blending. On start, reads the blended output buffer from SRAM,
//  words 143360..208895 (65536 RGB pixels), in 64-word blocks. Emits one 24-bit pixel per
//  accepted valid/ready beat to the display/file writer. Pulses stream_done after the last
//  pixel is accepted.
// PARAMETERS
//  ADDR_SIZE_BITS   24      SRAM word-address width
//  WORD_SIZE_BYTES  3       bytes per SRAM word; one word is one pixel
//  DATA_SIZE_WORDS  64      words per SRAM burst/block
//  BASE_ADDR        143360  first word of the output buffer
//  FRAME_WORDS      65536   pixels per frame; must be a multiple of DATA_SIZE_WORDS
// PORTS
//  clk           in   1      system clock, rising edge
//  n_rst         in   1      asynchronous active-low reset
//  stream_en     in   1      start pulse; sampled only in IDLE (normally wired to alpha_done)
//  stream_busy   out  1      high from the cycle after start until stream_done inclusive
//  stream_done   out  1      one-cycle pulse after the final pixel handshake
//  read_enable   out  1      SRAM read strobe
//  address       out  ADDR_SIZE_BITS   SRAM word address; 0 when not reading
//  read_data     in   WORD_SIZE_BYTES*DATA_SIZE_WORDS*8   SRAM block read data
//  pixel_data    out  24     pixel; word k of block = read_data[k*24 +: 24]
//  pixel_valid   out  1      pixel_data valid
//  pixel_ready   in   1      consumer accepts when pixel_valid && pixel_ready
//  pixel_last    out  1      high with final pixel of frame (index FRAME_WORDS-1)
// BEHAVIOUR
//  Reset: all outputs 0; block counter = 0; word index = 0; buffers cleared; state IDLE.
//  SRAM read protocol (shared with blend stage):
//   - Drive address and read_enable for 2 consecutive cycles.
//   - Capture read_data on the following cycle.
//  FSM:
//   - IDLE -> RD_REQ on stream_en.
//   - RD_REQ (addr=BASE_ADDR+blk*64, rd=1) -> RD_WAIT (same addr, rd=1) -> CAPTURE.
//   - CAPTURE: latch read_data into block buffer; word index = 0 -> DRAIN.
//   - DRAIN: pixel_valid=1, pixel_data=word[idx]. Data is held stable until handshake.
//     On handshake idx++. At idx=63 handshake: if blk==FRAME_WORDS/64-1 -> DONE,
//     else blk++ -> RD_REQ.
//   - DONE: stream_done=1 for one cycle -> IDLE; blk cleared.
//  Latency: first pixel_valid 4 cycles after the stream_en cycle.
//  Non-prefetch gap between blocks: 3 cycles with pixel_valid=0.
//  pixel_valid never drops without a handshake. pixel_ready while !pixel_valid is ignored.
//  stream_en while busy is ignored (no restart, no queue).
//  Address arithmetic is ADDR_SIZE_BITS wide. Last block read is at 208832.
//  Reset mid-frame: immediate abort to reset values; the next stream_en restarts at block 0.
// CONFIGURATION
//  OUTPUT_STREAM_PREFETCH_EN defined:
//   - Two block buffers (ping-pong).
//   - Fetch of block n+1 runs while block n drains, starting the cycle after CAPTURE of block n.
//   - Buffer swap on the idx=63 handshake; pixels are gapless if the next block has landed.
//   - No fetch beyond the last block.
//  Undefined: single buffer; fetch only after drain; behaviour exactly as above.
// STRUCTURE
//  Package gpu_mem_pkg:
//   - address-map constants: LAYER1_BASE=0, LAYER2_BASE=65536, TEX1/2/3_BASE, OUT_BASE=143360.
//   - BLOCK_WORDS=64.
//   - typedef pixel_t (logic [23:0]).
//   - output_stream state enum.
//  Sub-module stream_block_buf: holds the block(s), loads on capture, muxes word[idx] to
//  pixel_data, tracks idx and the ping-pong select.
//  Top level: FSM, block counter, SRAM strobes.
// TESTING
//  1 Reset with stream_en=0 -> all outputs 0, address=0 for 20 cycles.
//  2 stream_en pulse, ready=1, SRAM model word w = w[23:0] -> 65536 beats with pixel_data =
//    143360..208895 in order; pixel_last only on 208895; one stream_done pulse.
//  3 pixel_ready toggling 1-of-3 cycles -> pixel_data stable while valid&&!ready; no drop or
//    duplicate pixels.
//  4 Probe block boundary -> reads at 143360 then 143424, each strobed exactly 2 cycles.
//    Undefined macro: 3-cycle valid gap. With OUTPUT_STREAM_PREFETCH_EN and ready=1: no gap.
//  5 stream_en re-pulsed mid-frame -> ignored, sequence unchanged.
//    n_rst low at pixel 1000 -> outputs 0 at once; new start begins at 143360.
//  6 Frame ends -> stream_done, back to IDLE. Immediate second stream_en -> a full second frame
//    identical to the first.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// GPU memory map, shared pixel type and the output-stream FSM state encoding.
package gpu_mem_pkg;

    localparam int ADDR_BITS    = 32'd24;
    localparam int LAYER1_BASE  = 32'd0;
    localparam int LAYER2_BASE  = 32'd65536;
    localparam int TEX1_BASE    = 32'd131072;
    localparam int TEX2_BASE    = 32'd135168;
    localparam int TEX3_BASE    = 32'd139264;
    localparam int OUT_BASE     = 32'd143360;
    localparam int BLOCK_WORDS  = 32'd64;
    localparam int FRAME_PIXELS = 32'd65536;

    typedef logic [23:0] pixel_t;

    typedef enum logic [2:0] {
        OS_IDLE    = 3'd0,
        OS_RD_REQ  = 3'd1,
        OS_RD_WAIT = 3'd2,
        OS_CAPTURE = 3'd3,
        OS_DRAIN   = 3'd4,
        OS_PF_WAIT = 3'd5,
        OS_DONE    = 3'd6
    } os_state_e;

endpackage

// File: rtl/stream_block_buf.sv
// Block buffer for output_stream: holds the fetched block(s), tracks the word index and muxes
// the current pixel out. With OUTPUT_STREAM_PREFETCH_EN defined it keeps a ping-pong pair.
module stream_block_buf
    import gpu_mem_pkg::*;
#(
    parameter int WORDS = BLOCK_WORDS
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic                              load_i,
    input  logic                              load_alt_i,
    input  logic                              swap_i,
    input  logic                              adv_i,
    input  logic [WORDS*$bits(pixel_t)-1:0]   block_i,
    output logic [$clog2(WORDS)-1:0]          idx_o,
    output pixel_t                            word_o
);

    localparam int PIX_W = $bits(pixel_t);
    localparam int IDX_W = $clog2(WORDS);
    localparam int BUF_W = WORDS * PIX_W;

    logic [IDX_W-1:0] idx_q, idx_d;

    // Word index restarts on a fresh load and wraps to 0 after the last word's handshake.
    always_comb begin
        idx_d = idx_q;
        if (load_i) begin
            idx_d = '0;
        end else if (adv_i) begin
            idx_d = idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end
    end

    // Word index register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;

`ifdef OUTPUT_STREAM_PREFETCH_EN
    logic [BUF_W-1:0] buf_q [2];
    logic             sel_q;

    // Ping-pong storage: the active half drains while the standby half takes the next block.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            sel_q    <= 1'b0;
        end else begin
            if (load_i) begin
                buf_q[sel_q] <= block_i;
            end
            if (load_alt_i) begin
                buf_q[~sel_q] <= block_i;
            end
            if (swap_i) begin
                sel_q <= ~sel_q;
            end
        end
    end

    assign word_o = buf_q[sel_q][int'(idx_q)*PIX_W +: PIX_W];
`else
    logic [BUF_W-1:0] buf_q;
    logic             unused_s;

    // Single block store, refilled only after the previous block has fully drained.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            buf_q <= '0;
        end else if (load_i) begin
            buf_q <= block_i;
        end
    end

    assign word_o   = buf_q[int'(idx_q)*PIX_W +: PIX_W];
    assign unused_s = ^{load_alt_i, swap_i};
`endif

endmodule

// File: rtl/output_stream.sv
// Streams the blended output buffer from SRAM to a valid/ready pixel sink, one block at a time.
// Defining OUTPUT_STREAM_PREFETCH_EN overlaps the next block fetch with the current drain.
module output_stream
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_SIZE_BITS  = ADDR_BITS,
    parameter int WORD_SIZE_BYTES = 32'd3,
    parameter int DATA_SIZE_WORDS = BLOCK_WORDS,
    parameter int BASE_ADDR       = OUT_BASE,
    parameter int FRAME_WORDS     = FRAME_PIXELS
) (
    input  logic                                          clk,
    input  logic                                          n_rst,
    input  logic                                          stream_en,
    output logic                                          stream_busy,
    output logic                                          stream_done,
    output logic                                          read_enable,
    output logic [ADDR_SIZE_BITS-1:0]                     address,
    input  logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0]  read_data,
    output pixel_t                                        pixel_data,
    output logic                                          pixel_valid,
    input  logic                                          pixel_ready,
    output logic                                          pixel_last
);

    localparam int NUM_BLOCKS = FRAME_WORDS / DATA_SIZE_WORDS;
    localparam int BLK_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int IDX_W      = $clog2(DATA_SIZE_WORDS);
    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_BLOCKS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_SIZE_WORDS - 1);

    os_state_e        state_q, state_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [BLK_W-1:0] rd_blk_s;
    logic [IDX_W-1:0] idx_s;
    pixel_t           word_s;
    logic             hs_s, last_blk_s, last_word_s;
    logic             load_s, load_alt_s, swap_s;

    function automatic logic [ADDR_SIZE_BITS-1:0] blk_addr(input logic [BLK_W-1:0] blk);
        return ADDR_SIZE_BITS'(BASE_ADDR) +
               (ADDR_SIZE_BITS'(blk) * ADDR_SIZE_BITS'(DATA_SIZE_WORDS));
    endfunction

    assign pixel_valid = (state_q == OS_DRAIN);
    assign hs_s        = pixel_valid && pixel_ready;
    assign last_blk_s  = (blk_q == LAST_BLK);
    assign last_word_s = (idx_s == LAST_IDX);
    assign pixel_data  = pixel_valid ? word_s : '0;
    assign pixel_last  = pixel_valid && last_blk_s && last_word_s;
    assign stream_busy = (state_q != OS_IDLE);
    assign stream_done = (state_q == OS_DONE);

`ifdef OUTPUT_STREAM_PREFETCH_EN
    logic [1:0] pf_ph_q, pf_ph_d;
    logic       pf_rdy_q, pf_rdy_d;
`endif

    // Main sequencer: next state, block counter and buffer load/swap strobes.
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        load_s  = 1'b0;
        swap_s  = 1'b0;
        case (state_q)
            OS_IDLE: begin
                if (stream_en) begin
                    state_d = OS_RD_REQ;
                end else begin
                    state_d = OS_IDLE;
                end
            end
            OS_RD_REQ:  state_d = OS_RD_WAIT;
            OS_RD_WAIT: state_d = OS_CAPTURE;
            OS_CAPTURE: begin
                load_s  = 1'b1;
                state_d = OS_DRAIN;
            end
            OS_DRAIN: begin
                if (hs_s && last_word_s) begin
                    if (last_blk_s) begin
                        state_d = OS_DONE;
`ifdef OUTPUT_STREAM_PREFETCH_EN
                    end else if (pf_rdy_q) begin
                        swap_s  = 1'b1;
                        blk_d   = blk_q + BLK_W'(1);
                        state_d = OS_DRAIN;
                    end else begin
                        state_d = OS_PF_WAIT;
                    end
`else
                    end else begin
                        blk_d   = blk_q + BLK_W'(1);
                        state_d = OS_RD_REQ;
                    end
`endif
                end else begin
                    state_d = OS_DRAIN;
                end
            end
            OS_PF_WAIT: begin
`ifdef OUTPUT_STREAM_PREFETCH_EN
                if (pf_rdy_q) begin
                    swap_s  = 1'b1;
                    blk_d   = blk_q + BLK_W'(1);
                    state_d = OS_DRAIN;
                end else begin
                    state_d = OS_PF_WAIT;
                end
`else
                state_d = OS_IDLE;
`endif
            end
            OS_DONE: begin
                blk_d   = '0;
                state_d = OS_IDLE;
            end
            default: state_d = OS_IDLE;
        endcase
    end

    // Sequencer state and block counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= OS_IDLE;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
        end
    end

`ifdef OUTPUT_STREAM_PREFETCH_EN
    // Background fetch of block blk+1, launched whenever a new block becomes the draining one.
    always_comb begin
        pf_ph_d    = pf_ph_q;
        pf_rdy_d   = pf_rdy_q;
        load_alt_s = 1'b0;
        case (pf_ph_q)
            2'd0: begin
                if (((state_q == OS_CAPTURE) || swap_s) && (blk_d != LAST_BLK)) begin
                    pf_ph_d = 2'd1;
                end else begin
                    pf_ph_d = 2'd0;
                end
            end
            2'd1: pf_ph_d = 2'd2;
            2'd2: pf_ph_d = 2'd3;
            2'd3: begin
                load_alt_s = 1'b1;
                pf_rdy_d   = 1'b1;
                pf_ph_d    = 2'd0;
            end
            default: pf_ph_d = 2'd0;
        endcase
        if (swap_s) begin
            pf_rdy_d = 1'b0;
        end else begin
            pf_rdy_d = pf_rdy_d;
        end
    end

    // Prefetch phase and landed flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pf_ph_q  <= 2'd0;
            pf_rdy_q <= 1'b0;
        end else begin
            pf_ph_q  <= pf_ph_d;
            pf_rdy_q <= pf_rdy_d;
        end
    end
`else
    assign load_alt_s = 1'b0;
`endif

    // SRAM strobes; the address bus idles at zero whenever no read is in flight.
    always_comb begin
        read_enable = 1'b0;
        rd_blk_s    = blk_q;
        if ((state_q == OS_RD_REQ) || (state_q == OS_RD_WAIT)) begin
            read_enable = 1'b1;
        end
`ifdef OUTPUT_STREAM_PREFETCH_EN
        else if ((pf_ph_q == 2'd1) || (pf_ph_q == 2'd2)) begin
            read_enable = 1'b1;
            rd_blk_s    = blk_q + BLK_W'(1);
        end
`endif
        else begin
            read_enable = 1'b0;
        end
        address = read_enable ? blk_addr(rd_blk_s) : '0;
    end

    stream_block_buf #(
        .WORDS (DATA_SIZE_WORDS)
    ) u_buf (
        .clk        (clk),
        .n_rst      (n_rst),
        .load_i     (load_s),
        .load_alt_i (load_alt_s),
        .swap_i     (swap_s),
        .adv_i      (hs_s),
        .block_i    (read_data),
        .idx_o      (idx_s),
        .word_o     (word_s)
    );

endmodule

// File: tb/tb_output_stream.sv
// Randomized self-checking bench for output_stream: SRAM model plus a pixel-sequence scoreboard.
module tb_output_stream;

    localparam int BASE   = 143360;
    localparam int FRAME  = 65536;
    localparam int BWORDS = 64;
    localparam int NBLK   = FRAME / BWORDS;
`ifdef OUTPUT_STREAM_PREFETCH_EN
    localparam int EXP_GAP = 0;
`else
    localparam int EXP_GAP = 3;
`endif

    logic          clk, n_rst, stream_en, pixel_ready;
    logic          stream_busy, stream_done, read_enable, pixel_valid, pixel_last;
    logic [23:0]   address, pixel_data;
    logic [1535:0] read_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0;
    bit ready_rand = 1'b0;

    output_stream dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .stream_en   (stream_en),
        .stream_busy (stream_busy),
        .stream_done (stream_done),
        .read_enable (read_enable),
        .address     (address),
        .read_data   (read_data),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .pixel_last  (pixel_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_busy"}, stream_busy, 0);
        check_val({tag, "_done"}, stream_done, 0);
        check_val({tag, "_rd"},   read_enable, 0);
        check_val({tag, "_addr"}, address, 0);
        check_val({tag, "_valid"}, pixel_valid, 0);
        check_val({tag, "_last"}, pixel_last, 0);
        check_val({tag, "_data"}, pixel_data, 0);
    endtask

    // SRAM: data appears only after the same address was strobed on two consecutive cycles.
    logic        sram_ok = 1'b0;
    logic        sram_prev_rd = 1'b0;
    logic [23:0] sram_prev_addr = 24'd0;
    logic [23:0] sram_addr = 24'd0;
    always @(posedge clk) begin
        sram_ok        <= read_enable && sram_prev_rd && (address == sram_prev_addr);
        sram_addr      <= address;
        sram_prev_rd   <= read_enable;
        sram_prev_addr <= address;
    end
    always_comb begin
        read_data = '0;
        for (int k = 0; k < BWORDS; k++) begin
            read_data[k*24 +: 24] = sram_ok ? 24'(sram_addr + 24'(k)) : 24'hA5A5A5;
        end
    end

    initial begin
        pixel_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pixel_ready = ready_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
        end
    end

    // Scoreboard state: the frame is simply the address sequence BASE .. BASE+FRAME-1.
    int          exp_idx = 0, rd_blk = 0, run_len = 0, gap = 0, done_cnt = 0;
    logic [23:0] run_addr = 24'd0, prev_data = 24'd0;
    bit          prev_valid = 0, prev_ready = 0, last_hs = 0, gap_meas = 0;

    task automatic close_run();
        check_val("rd_addr", run_addr, BASE + rd_blk * BWORDS);
        check_val("rd_len", run_len, 2);
        rd_blk  = (rd_blk + 1) % NBLK;
        run_len = 0;
    endtask

    always @(negedge clk) begin
        if (!n_rst) begin
            exp_idx = 0; rd_blk = 0; run_len = 0; gap_meas = 0;
            prev_valid = 0; prev_ready = 0; last_hs = 0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check_val("valid_hold", pixel_valid, 1);
                check_val("data_hold", pixel_data, prev_data);
            end
            if (stream_done || last_hs) begin
                check_val("done_pulse", stream_done, last_hs);
            end
            if (stream_done) done_cnt++;
            last_hs = 0;
            if (gap_meas) begin
                if (pixel_valid) begin
                    check_val("block_gap", gap, EXP_GAP);
                    gap_meas = 0;
                end else begin
                    gap++;
                end
            end
            if (!pixel_valid) begin
                check_val("last_idle", pixel_last, 0);
            end
            if (pixel_valid && pixel_ready) begin
                check_val("pixel_data", pixel_data, BASE + exp_idx);
                check_val("pixel_last", pixel_last, exp_idx == FRAME - 1);
                if (exp_idx == FRAME - 1) begin
                    exp_idx = 0;
                    last_hs = 1;
                end else begin
                    if (exp_idx % BWORDS == BWORDS - 1) begin
                        gap_meas = 1;
                        gap = 0;
                    end
                    exp_idx++;
                end
            end
            if (read_enable) begin
                if (run_len > 0 && address == run_addr) begin
                    run_len++;
                end else begin
                    if (run_len > 0) close_run();
                    run_addr = address;
                    run_len  = 1;
                end
            end else begin
                check_val("addr_idle", address, 0);
                if (run_len > 0) close_run();
            end
            prev_valid = pixel_valid;
            prev_ready = pixel_ready;
            prev_data  = pixel_data;
        end
    end

    initial begin
        n_rst     = 1'b0;
        stream_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;

        repeat (20) begin
            @(negedge clk);
            check_idle("reset");
        end

        // Full frame with an always-ready sink.
        @(posedge clk);
        #1 stream_en = 1'b1;
        t0 = cyc;
        @(negedge clk);
        check_val("busy_pre", stream_busy, 0);
        @(posedge clk);
        #1 stream_en = 1'b0;
        @(negedge clk);
        check_val("busy_post", stream_busy, 1);
        for (int i = 0; i < 20 && !pixel_valid; i++) @(negedge clk);
        check_val("first_valid_seen", pixel_valid, 1);
        check_val("latency", cyc - t0, 4);

        // A start pulse mid-frame must not disturb the sequence.
        repeat (5000) @(posedge clk);
        #1 stream_en = 1'b1;
        @(posedge clk);
        #1 stream_en = 1'b0;

        for (int i = 0; i < 80000 && !stream_done; i++) @(negedge clk);
        check_val("frame_done_seen", stream_done, 1);
        check_val("frame_done_busy", stream_busy, 1);

        // Immediate restart after done, now with a throttling sink.
        @(posedge clk);
        #1 stream_en = 1'b1;
        ready_rand = 1'b1;
        @(negedge clk);
        check_val("idle_after_done", stream_busy, 0);
        check_val("done_count", done_cnt, 1);
        @(posedge clk);
        #1 stream_en = 1'b0;

        for (int i = 0; i < 10000 && exp_idx < 1000; i++) @(negedge clk);
        check_val("reach_1000", exp_idx >= 1000, 1);

        // Asynchronous abort mid-frame.
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1 check_idle("abort");
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        check_idle("post_abort");

        @(posedge clk);
        #1 stream_en = 1'b1;
        @(posedge clk);
        #1 stream_en = 1'b0;
        for (int i = 0; i < 5000 && exp_idx < 300; i++) @(negedge clk);
        check_val("restart_progress", exp_idx >= 300, 1);
        check_val("done_total", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
